hvsync_detector: RTL

HVSYNC_DETECTOR -- requirements
Module: hvsync_detector

---
 rtl/hvsync_detector.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hvsync_detector.sv
// Recovers pixel position and lock status from a raw hsync/vsync pair by measuring
// line and frame periods against the expected totals.
module hvsync_detector #(
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned H_RISE_POS = 659,
  parameter int unsigned V_RISE_POS = 490,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       hlock,
  output logic       locked
);

  localparam logic [9:0] HTotal  = 10'(H_TOTAL);
  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VTotal  = 10'(V_TOTAL);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HDisp   = 10'(H_DISPLAY);
  localparam logic [9:0] VDisp   = 10'(V_DISPLAY);
  localparam logic [9:0] HRise   = 10'(H_RISE_POS);
  localparam logic [9:0] VRise   = 10'(V_RISE_POS);
  localparam logic [9:0] LockCnt = 10'(LOCK_COUNT);
  localparam logic [9:0] CntMax  = 10'h3ff;

  typedef enum logic [1:0] {StUnlocked, StHLocked, StLocked} state_e;

  state_e     state_q, state_d;
  logic       hs_d1_q, hs_d2_q, vs_d1_q, vs_d2_q;
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0] line_len_q, frame_lines_q, hgood_q, hgood_d, line_meas;
  logic       h_seen_q, v_seen_q, armed_q, armed_d;
  logic       display_on_q, hlock_q, locked_q;
  logic       h_rise, v_rise, h_wrap, good_line, bad_line, frame_judge, good_frame, bad_frame;

  always_comb begin
    h_rise = hs_d1_q & ~hs_d2_q;
    v_rise = vs_d1_q & ~vs_d2_q;
    h_wrap = ~h_rise & (hpos_q == HLast);

    hpos_d = h_rise ? HRise : (h_wrap ? '0 : hpos_q + 10'd1);
    vpos_d = vpos_q;
    if (v_rise) begin
      vpos_d = VRise;
    end else if (h_wrap) begin
      vpos_d = (vpos_q == VLast) ? '0 : vpos_q + 10'd1;
    end

    line_meas = (h_cnt_q == CntMax) ? CntMax : h_cnt_q + 10'd1;
    h_cnt_d   = h_rise ? '0 : line_meas;
    v_cnt_d   = v_cnt_q;
    if (v_rise) begin
      v_cnt_d = '0;
    end else if (h_rise && v_cnt_q != CntMax) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end

    // Timeout fires once, on the cycle h_cnt steps onto its ceiling.
    good_line   = h_rise & h_seen_q & (line_meas == HTotal);
    bad_line    = (h_rise & h_seen_q & (line_meas != HTotal)) |
                  (~h_rise & (h_cnt_q == CntMax - 10'd1));
    frame_judge = v_rise & armed_q;
    good_frame  = frame_judge & (v_cnt_q == VTotal);
    bad_frame   = frame_judge & (v_cnt_q != VTotal);

    state_d = state_q;
    hgood_d = hgood_q;
    case (state_q)
      StUnlocked: begin
        if (bad_line) begin
          hgood_d = '0;
        end else if (good_line) begin
          if (hgood_q + 10'd1 >= LockCnt) begin
            state_d = StHLocked;
            hgood_d = '0;
          end else begin
            hgood_d = hgood_q + 10'd1;
          end
        end
      end
      StHLocked: begin
        if (bad_line)        state_d = StUnlocked;
        else if (good_frame) state_d = StLocked;
      end
      StLocked: begin
        if (bad_line)       state_d = StUnlocked;
        else if (bad_frame) state_d = StHLocked;
      end
      default: state_d = StUnlocked;
    endcase

    // The first vsync after gaining horizontal lock only restarts v_cnt.
    armed_d = armed_q;
    if (state_q == StUnlocked) armed_d = 1'b0;
    else if (v_rise)           armed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StUnlocked;
      hs_d1_q       <= 1'b0;
      hs_d2_q       <= 1'b0;
      vs_d1_q       <= 1'b0;
      vs_d2_q       <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      hgood_q       <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      armed_q       <= 1'b0;
      display_on_q  <= 1'b0;
      hlock_q       <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_d1_q  <= hsync_in;
      hs_d2_q  <= hs_d1_q;
      vs_d1_q  <= vsync_in;
      vs_d2_q  <= vs_d1_q;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hgood_q  <= hgood_d;
      armed_q  <= armed_d;
      h_seen_q <= h_seen_q | h_rise;
      v_seen_q <= v_seen_q | v_rise;
      if (h_rise && h_seen_q) line_len_q <= line_meas;
      if (v_rise && v_seen_q) frame_lines_q <= v_cnt_q;
      display_on_q <= (state_d == StLocked) & (hpos_d < HDisp) & (vpos_d < VDisp);
      hlock_q      <= (state_d != StUnlocked);
      locked_q     <= (state_d == StLocked);
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign display_on  = display_on_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign hlock       = hlock_q;
  assign locked      = locked_q;

endmodule
